sb_rx_deserializer: RTL
=======================

// Module: sb_rx_deserializer
// PURPOSE
//  Sideband RX deserializer; sits directly upstream of the SB pattern detector.
//  - Samples the serial sideband bit stream on i_clk and frames it into 64-bit packets, LSB first.
//  - Delivers each packet as o_de_ser_data with a one-cycle o_de_ser_valid strobe.
//  - Checks framing:
//    - a packet is exactly 64 consecutive valid bits;
//    - consecutive packets are separated by >= GAP_MIN invalid cycles (sideband clock gated).
// PARAMETERS
//  DATA_W   64  packet width in bits; bit counter width is $clog2(DATA_W)
//  GAP_MIN  32  minimum number of invalid cycles required between packets
// PORTS
//  i_clk            in   1       sideband RX clock; single clock domain
//  i_rst            in   1       asynchronous, active-high reset
//  i_enable         in   1       block enable; low forces IDLE and clears all counters
//  i_ser_bit        in   1       serial sideband data bit
//  i_ser_bit_valid  in   1       i_ser_bit is a live UI this cycle (sideband clock not gated)
//  o_de_ser_data    out  DATA_W  assembled packet, bit0 = first received bit
//  o_de_ser_valid   out  1       one-cycle strobe: o_de_ser_data holds a new packet
//  o_frame_err      out  1       one-cycle strobe: valid dropped mid-packet; partial packet discarded
//  o_gap_err        out  1       one-cycle strobe: new packet started before GAP_MIN invalid cycles
// BEHAVIOUR
//  Reset values: o_de_ser_data=0, o_de_ser_valid=0, o_frame_err=0, o_gap_err=0;
//   state=IDLE, bit_cnt=0, gap_cnt=0, shift_reg=0.
//  States: IDLE, SHIFT, GAP.
//  - IDLE:
//    - valid=1: shift_reg[0]<=bit, bit_cnt<=1, go SHIFT.
//  - SHIFT:
//    - valid=1: shift_reg[bit_cnt]<=bit, bit_cnt<=bit_cnt+1.
//    - On bit index DATA_W-1: next cycle o_de_ser_data<=full word and o_de_ser_valid=1;
//      bit_cnt<=0, gap_cnt<=0, go GAP.
//    - valid=0 with bit_cnt in 1..DATA_W-1: o_frame_err=1 next cycle;
//      discard partial, bit_cnt<=0, go IDLE (gap requirement waived).
//  - GAP:
//    - valid=0: gap_cnt increments, saturating at GAP_MIN.
//    - valid=1 and gap_cnt>=GAP_MIN: accept the bit as bit0 of a new packet, go SHIFT, no error.
//    - valid=1 and gap_cnt<GAP_MIN: o_gap_err=1 next cycle; the bit is still accepted
//      as bit0 of a new packet, go SHIFT.
//  Latency: o_de_ser_valid asserts exactly 1 cycle after the 64th bit is sampled.
//  o_de_ser_data holds its value until the next packet completes.
//   It is never cleared by errors or by i_enable.
//  o_de_ser_valid, o_frame_err and o_gap_err are mutually exclusive and never
//   asserted for two consecutive cycles.
//  i_enable=0 (any state, including mid-packet): next cycle state=IDLE, bit_cnt=0, gap_cnt=0.
//   No strobes are raised, a partial packet is silently dropped, and serial input is ignored.
//  Back-to-back bits with no gap across a packet boundary: the 65th consecutive valid bit
//   raises o_gap_err and becomes bit0 of the next packet. No bits are lost.
//  Reset asserted mid-packet: all state returns to reset values immediately (async).
//   The first valid bit after deassertion is bit0.
//  Counter arithmetic: bit_cnt compares against DATA_W-1 and never wraps;
//   gap_cnt saturates and never wraps.
// STRUCTURE
//  Package sb_rx_pkg holds:
//  - state enum {IDLE, SHIFT, GAP};
//  - SB_PKT_W=64, SB_GAP_MIN=32;
//  - SB_PATTERN=64'hAAAA_AAAA_AAAA_AAAA, shared with the pattern generator/detector.
//  No sub-module: one FSM block plus a datapath block (shift register, counters, output regs).
// TESTING
//  - Reset: hold i_rst for 3 cycles, then release -> all outputs 0, state IDLE.
//  - Pattern packet: 64 valid bits of 64'hAAAA_AAAA_AAAA_AAAA LSB first
//    -> one cycle after the last bit, o_de_ser_data=64'hAAAA_AAAA_AAAA_AAAA, o_de_ser_valid=1 for 1 cycle.
//  - Two packets: 64'h0123_4567_89AB_CDEF, then 32 invalid cycles, then 64'hFFFF_0000_FFFF_0000
//    -> two valid strobes carrying those words; no error strobes.
//  - Short gap: packet, 10 invalid cycles, then packet 64'h1
//    -> o_gap_err pulses 1 cycle after the first new bit; second strobe still delivers 64'h1.
//  - Mid-packet drop: 40 valid bits, then valid=0 -> o_frame_err 1-cycle pulse, no o_de_ser_valid.
//    A following full 64-bit packet (after >=1 idle cycle) is delivered correctly.
//  - Enable/reset abort: drop i_enable (and separately assert i_rst) after 20 bits
//    -> no strobes; the next full packet decodes correctly with bit0 aligned.

Source files
------------

// File: rtl/sb_rx_deserializer_pkg.sv
// Shared sideband RX definitions: packet geometry, gap rule and the link-training pattern.
package sb_rx_pkg;

  localparam int SB_PKT_W   = 64;
  localparam int SB_GAP_MIN = 32;
  localparam logic [SB_PKT_W-1:0] SB_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } sb_rx_state_e;

endpackage

// File: rtl/sb_rx_deserializer_if.sv
// Serial-in / packet-out bundle between the sideband PHY and the deserializer.
interface sb_rx_deserializer_if #(
  parameter int DATA_W = 64
);
  logic              i_enable;
  logic              i_ser_bit;
  logic              i_ser_bit_valid;
  logic [DATA_W-1:0] o_de_ser_data;
  logic              o_de_ser_valid;
  logic              o_frame_err;
  logic              o_gap_err;

  modport slave (
    input  i_enable, i_ser_bit, i_ser_bit_valid,
    output o_de_ser_data, o_de_ser_valid, o_frame_err, o_gap_err
  );

  modport master (
    output i_enable, i_ser_bit, i_ser_bit_valid,
    input  o_de_ser_data, o_de_ser_valid, o_frame_err, o_gap_err
  );
endinterface

// File: rtl/sb_rx_deserializer.sv
// Frames the gated sideband bit stream into LSB-first packets and flags framing
// (valid dropped mid-packet) and inter-packet gap violations.
module sb_rx_deserializer
  import sb_rx_pkg::*;
#(
  parameter int DATA_W  = SB_PKT_W,
  parameter int GAP_MIN = SB_GAP_MIN
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sb_rx_deserializer_if.slave  sb
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int GCNT_W = $clog2(GAP_MIN + 1);

  sb_rx_state_e        state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GCNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                gerr_q, gerr_d;

  // FSM control decoded from state and the incoming UI
  logic load_first, shift_in, complete, gap_inc, clr_cnt;
  logic last_bit, gap_short;

  assign last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign gap_short = (gap_cnt_q < GCNT_W'(GAP_MIN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    shift_in   = 1'b0;
    complete   = 1'b0;
    gap_inc    = 1'b0;
    clr_cnt    = 1'b0;
    ferr_d     = 1'b0;
    gerr_d     = 1'b0;
    if (!sb.i_enable) begin
      state_d = IDLE;
      clr_cnt = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sb.i_ser_bit_valid) begin
            load_first = 1'b1;
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          if (sb.i_ser_bit_valid) begin
            shift_in = 1'b1;
            if (last_bit) begin
              complete = 1'b1;
              clr_cnt  = 1'b1;
              state_d  = GAP;
            end
          end else begin
            // Partial packet is abandoned; the next packet need not honour a gap.
            ferr_d  = 1'b1;
            clr_cnt = 1'b1;
            state_d = IDLE;
          end
        end
        GAP: begin
          if (sb.i_ser_bit_valid) begin
            load_first = 1'b1;
            gerr_d     = gap_short;
            state_d    = SHIFT;
          end else begin
            gap_inc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    valid_d   = complete;
    if (clr_cnt) begin
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end
    if (load_first) begin
      shift_d[0] = sb.i_ser_bit;
      bit_cnt_d  = CNT_W'(1);
    end else if (shift_in) begin
      shift_d[bit_cnt_q] = sb.i_ser_bit;
      if (!last_bit) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    // Word is taken straight from the final UI so it is visible one cycle later.
    if (complete) data_d = {sb.i_ser_bit, shift_q[DATA_W-2:0]};
    if (gap_inc && gap_short) gap_cnt_d = gap_cnt_q + GCNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      gerr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      gerr_q    <= gerr_d;
    end
  end

  assign sb.o_de_ser_data  = data_q;
  assign sb.o_de_ser_valid = valid_q;
  assign sb.o_frame_err    = ferr_q;
  assign sb.o_gap_err      = gerr_q;

endmodule
